// File: rtl/fpga_ctrl_pkg.sv
// fpga_ctrl_pkg: opcodes and FSM states shared by the LED/ADC controller
package fpga_ctrl_pkg;
  localparam logic [6:0] OP_ADC_SEL   = 7'h01;
  localparam logic [6:0] OP_RED_ON    = 7'h02;
  localparam logic [6:0] OP_RED_OFF   = 7'h03;
  localparam logic [6:0] OP_GRN_ON    = 7'h04;
  localparam logic [6:0] OP_GRN_OFF   = 7'h05;
  localparam logic [6:0] OP_RED_TGL   = 7'h06;
  localparam logic [6:0] OP_GRN_TGL   = 7'h07;
  localparam logic [6:0] OP_BLINK_ON  = 7'h08;
  localparam logic [6:0] OP_BLINK_OFF = 7'h09;
  localparam logic [6:0] OP_ALL_OFF   = 7'h0A;
  localparam logic [6:0] OP_ADC_NONE  = 7'h0B;
  typedef enum logic [1:0] {IDLE, EXEC, SETTLE} state_t;
endpackage

// File: rtl/blink_prescaler.sv
// blink_prescaler: free-running divider that flips phase every BLINK_DIV clocks
module blink_prescaler #(
  parameter int BLINK_DIV = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic phase
);
  localparam int PW = $clog2(BLINK_DIV);
  logic [PW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      phase <= 1'b0;
    end else if (cnt == PW'(BLINK_DIV - 1)) begin
      cnt <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end
endmodule

// File: rtl/fpga_led_adc_ctrl.sv
// fpga_led_adc_ctrl: command-driven red/green LED control with break-before-make ADC select
module fpga_led_adc_ctrl
  import fpga_ctrl_pkg::*;
#(
  parameter int NUM_LEDS      = 35,
  parameter int NUM_ADCS      = 18,
  parameter int BLINK_DIV     = 1000000,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [6:0]          command,
  input  logic [7:0]          data,
  output logic [NUM_LEDS-1:0] rleds,
  output logic [NUM_LEDS-1:0] gleds,
  output logic [NUM_ADCS-1:0] adcs,
  output logic                busy,
  output logic                err
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  state_t state, state_nx;
  logic [6:0] cmd_q;
  logic [7:0] data_q;
  logic [NUM_LEDS-1:0] red, grn, blink_mask, led_bit;
  logic [NUM_ADCS-1:0] adc_bit, adc_pend;
  logic [CW-1:0] cnt;
  logic phase, bad, is_adc, led_op;

  blink_prescaler #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .clk(clk),
    .rst_n(rst_n),
    .phase(phase)
  );

  always_comb begin
    led_bit = NUM_LEDS'(1) << data_q;
    adc_bit = NUM_ADCS'(1) << data_q[7:1];
    led_op = cmd_q inside {[OP_RED_ON:OP_BLINK_OFF]};
    is_adc = cmd_q == OP_ADC_SEL || cmd_q == OP_ADC_NONE;
    bad = !(is_adc || led_op || cmd_q == OP_ALL_OFF)
        || (led_op && 32'(data_q) >= NUM_LEDS)
        || (cmd_q == OP_ADC_SEL && 32'(data_q[7:1]) >= NUM_ADCS);
    cmd_ready = rst_n && state == IDLE;
    busy = state == SETTLE;
    err = state == EXEC && bad;
    state_nx = state == IDLE ? (cmd_valid ? EXEC : IDLE)
             : state == EXEC ? (is_adc && !bad ? SETTLE : IDLE)
             : state == SETTLE && cnt != CW'(1) ? SETTLE : IDLE;
    rleds = (red & ~blink_mask) | (blink_mask & {NUM_LEDS{phase}});
    gleds = grn;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= '0;
      data_q <= '0;
      red <= '0;
      grn <= '0;
      blink_mask <= '0;
      adcs <= '0;
      adc_pend <= '0;
      cnt <= '0;
    end else begin
      if (cmd_ready && cmd_valid) begin
        cmd_q <= command;
        data_q <= data;
      end
      if (state == EXEC && !bad) begin
        red <= cmd_q == OP_RED_ON ? red | led_bit : cmd_q == OP_RED_OFF ? red & ~led_bit
             : cmd_q == OP_RED_TGL ? red ^ led_bit : cmd_q == OP_ALL_OFF ? '0 : red;
        grn <= cmd_q == OP_GRN_ON ? grn | led_bit : cmd_q == OP_GRN_OFF ? grn & ~led_bit
             : cmd_q == OP_GRN_TGL ? grn ^ led_bit : cmd_q == OP_ALL_OFF ? '0 : grn;
        blink_mask <= cmd_q == OP_BLINK_ON ? blink_mask | led_bit
                    : cmd_q == OP_BLINK_OFF ? blink_mask & ~led_bit
                    : cmd_q == OP_ALL_OFF ? '0 : blink_mask;
        if (is_adc) begin
          adcs <= '0;
          cnt <= CW'(SETTLE_CYCLES);
          adc_pend <= cmd_q == OP_ADC_SEL ? adc_bit : '0;
        end
      end
      // The pending select only reaches adcs on the final settle edge
      if (state == SETTLE) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) adcs <= adc_pend;
      end
    end
  end
endmodule

// File: tb/tb_fpga_led_adc_ctrl.sv
// tb_fpga_led_adc_ctrl: directed and random commands checked against a bit-level behavioural model
module tb_fpga_led_adc_ctrl;
  localparam int NL = 35;
  localparam int NA = 18;
  localparam int BD = 4;
  localparam int SC = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [6:0] command = '0;
  logic [7:0] data = '0;
  logic [NL-1:0] rleds, gleds;
  logic [NA-1:0] adcs;
  logic busy, err;

  int vectors = 0;
  int miscompares = 0;
  int edges = 0;
  logic [NL-1:0] m_red = '0, m_grn = '0, m_blink = '0;
  logic [NA-1:0] m_adc = '0, m_pend = '0;

  fpga_led_adc_ctrl #(
    .NUM_LEDS(NL),
    .NUM_ADCS(NA),
    .BLINK_DIV(BD),
    .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .command(command),
    .data(data),
    .rleds(rleds),
    .gleds(gleds),
    .adcs(adcs),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; blink phase is how many whole BD periods have elapsed, mod 2
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else edges <= edges + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    logic [NL-1:0] r;
    logic ph;
    ph = ((edges / BD) % 2) == 1;
    for (int i = 0; i < NL; i++) r[i] = m_blink[i] ? ph : m_red[i];
    chk({tag, "_rleds"}, 64'(rleds), 64'(r));
    chk({tag, "_gleds"}, 64'(gleds), 64'(m_grn));
    chk({tag, "_adcs"}, 64'(adcs), 64'(m_adc));
  endtask

  task automatic apply(input logic [6:0] op, input logic [7:0] d);
    logic [NL-1:0] b;
    b = NL'(1) << d;
    case (op)
      7'h01: begin m_adc = '0; m_pend = NA'(1) << (d / 2); end
      7'h02: m_red |= b;
      7'h03: m_red &= ~b;
      7'h04: m_grn |= b;
      7'h05: m_grn &= ~b;
      7'h06: m_red ^= b;
      7'h07: m_grn ^= b;
      7'h08: m_blink |= b;
      7'h09: m_blink &= ~b;
      7'h0A: begin m_red = '0; m_grn = '0; m_blink = '0; end
      7'h0B: begin m_adc = '0; m_pend = '0; end
      default: ;
    endcase
  endtask

  task automatic do_cmd(input logic [6:0] op, input logic [7:0] d);
    logic bad, adc_op;
    bad = !(op >= 7'h01 && op <= 7'h0B) || (op >= 7'h02 && op <= 7'h09 && d >= 8'(NL))
        || (op == 7'h01 && d / 2 >= 8'(NA));
    adc_op = !bad && (op == 7'h01 || op == 7'h0B);
    @(negedge clk);
    command = op;
    data = d;
    cmd_valid = 1'b1;
    chk("ready_idle", 64'(cmd_ready), 64'(1));
    @(negedge clk);
    cmd_valid = 1'b0;
    command = 7'($urandom);
    data = 8'($urandom);
    chk("ready_exec", 64'(cmd_ready), 64'(0));
    chk("err_exec", 64'(err), 64'(bad));
    chk("busy_exec", 64'(busy), 64'(0));
    chk_outs("exec");
    if (!bad) apply(op, d);
    @(negedge clk);
    chk("err_after", 64'(err), 64'(0));
    if (adc_op) begin
      for (int i = 0; i < SC; i++) begin
        if (i > 0) @(negedge clk);
        chk("busy_settle", 64'(busy), 64'(1));
        chk("ready_settle", 64'(cmd_ready), 64'(0));
        chk_outs("settle");
      end
      @(negedge clk);
      m_adc = m_pend;
    end
    chk("busy_done", 64'(busy), 64'(0));
    chk("ready_done", 64'(cmd_ready), 64'(1));
    chk_outs("done");
  endtask

  initial begin
    int n;
    logic prev;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(cmd_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk_outs("rst");
    rst_n = 1'b1;
    #1 chk("rel_ready", 64'(cmd_ready), 64'(1));

    do_cmd(7'h02, 8'd3);
    chk("red3", 64'(rleds), 64'h8);
    do_cmd(7'h04, 8'd34);
    chk("grn34", 64'(gleds), 64'h4_0000_0000);

    do_cmd(7'h01, 8'd10);
    chk("adc10", 64'(adcs), 64'h20);

    do_cmd(7'h02, 8'd35);
    do_cmd(7'h7F, 8'd0);
    chk("bad_keep_adc", 64'(adcs), 64'h20);
    chk("bad_keep_red", 64'(rleds), 64'h8);

    do_cmd(7'h0A, 8'd0);
    chk("alloff_adc", 64'(adcs), 64'h20);
    do_cmd(7'h08, 8'd0);
    prev = rleds[0];
    n = 0;
    for (int i = 0; i < 4 * BD; i++) begin
      @(negedge clk);
      if (rleds[0] !== prev) n++;
      prev = rleds[0];
      chk_outs("blink");
    end
    chk("blink_toggles", 64'(n), 64'(4));
    do_cmd(7'h09, 8'd0);
    chk("blink_off", 64'(rleds), 64'(0));

    @(negedge clk);
    command = 7'h06;
    data = 8'd1;
    cmd_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("b2b_ready", 64'(cmd_ready), 64'(k % 2 == 0));
      if (k % 2 == 1) m_red ^= NL'(2);
      @(negedge clk);
      chk_outs("b2b");
    end
    cmd_valid = 1'b0;
    chk("b2b_red1", 64'(rleds[1]), 64'(1));

    for (int t = 0; t < 150; t++) begin
      int r;
      r = int'($urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_cmd(r == 15 ? 7'h7F : 7'(r), 8'($urandom_range(0, 40)));
    end

    @(negedge clk);
    command = 7'h01;
    data = 8'd4;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rleds", 64'(rleds), 64'(0));
    chk("arst_gleds", 64'(gleds), 64'(0));
    chk("arst_adcs", 64'(adcs), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_err", 64'(err), 64'(0));
    chk("arst_ready", 64'(cmd_ready), 64'(0));
    m_red = '0;
    m_grn = '0;
    m_blink = '0;
    m_adc = '0;
    m_pend = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel2_ready", 64'(cmd_ready), 64'(1));
    for (int i = 0; i < SC + 4; i++) begin
      @(negedge clk);
      chk("post_busy", 64'(busy), 64'(0));
      chk_outs("post_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
